// File: rtl/io_bridge_pkg.sv
// Shared constants for the processor I/O bridge: bus widths and strobe position.
package io_bridge_pkg;

  localparam int IO_DATA_W     = 16;
  localparam int IO_STROBE_BIT = 16;
  localparam int IO_OUT_W      = 17;

  // A write is the rising edge of the strobe, never its level.
  function automatic logic is_write_event(input logic strobe, input logic strobe_q);
    return strobe & ~strobe_q;
  endfunction

endpackage

// File: rtl/io_bridge_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; contents are not reset,
// only the pointers are.
module io_bridge_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // When full, a same-cycle push and pop share one slot: the old word is read
  // out combinationally this cycle and overwritten at the edge.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/io_bridge.sv
// Host-side endpoint for the processor's 16-bit I/O port: queues strobed writes,
// holds a host word for ioIn. Optional drop counter: IO_BRIDGE_DROP_CNT_EN.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [IO_OUT_W-1:0]  proc_out,
  output logic [IO_DATA_W-1:0] proc_in,
  output logic [IO_DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic [IO_DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                ovf,
  input  logic                ovf_clr,
  output logic [CNT_W-1:0]    drop_cnt
);

  logic                 r_strb_q;
  logic [IO_DATA_W-1:0] r_proc_in;
  logic                 r_in_ready;
  logic                 r_ovf;
  logic                 w_event;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  // Handshakes: a word transfers on a rising clk edge where valid & ready are
  // both 1; valid never depends on ready, and ready with valid low does nothing.
  assign w_event = is_write_event(proc_out[IO_STROBE_BIT], r_strb_q);
  assign w_pop   = ~w_empty & out_ready;
  assign w_push  = w_event & (~w_full | w_pop);
  assign w_drop  = w_event & w_full & ~w_pop;

  io_bridge_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IO_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (Reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (proc_out[IO_DATA_W-1:0]),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_strb_q   <= 1'b0;
      r_proc_in  <= '0;
      r_in_ready <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_strb_q   <= proc_out[IO_STROBE_BIT];
      r_in_ready <= 1'b1;
      if (in_valid && r_in_ready) r_proc_in <= in_data;
      if (ovf_clr)     r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef IO_BRIDGE_DROP_CNT_EN
  logic [CNT_W-1:0] r_drop_cnt;

  // Clear wins over a same-cycle drop; the count saturates at all-ones.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_drop_cnt <= '0;
    end else if (ovf_clr) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

  assign proc_in   = r_proc_in;
  assign in_ready  = r_in_ready;
  assign ovf       = r_ovf;
  assign out_valid = ~w_empty;

endmodule

// File: tb/tb_io_bridge.sv
// Directed self-checking bench for io_bridge: strobe timing, FIFO order,
// overflow, full push/pop, host path and asynchronous reset.
module tb_io_bridge;

  logic        clk;
  logic        Reset;
  logic [16:0] proc_out;
  logic [15:0] proc_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;

  int n_tests;
  int n_fail;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

`ifdef IO_BRIDGE_DROP_CNT_EN
  localparam logic [7:0] EXP_DROP_TWO = 8'd2;
`else
  localparam logic [7:0] EXP_DROP_TWO = 8'd0;
`endif

  io_bridge #(.DEPTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .proc_out  (proc_out),
    .proc_in   (proc_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .drop_cnt  (drop_cnt)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] d);
    proc_out = {1'b1, d};
    tick();
    proc_out = {1'b0, d};
    tick();
  endtask

  task automatic drain(input int max_cycles);
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (!out_valid) break;
      got_q.push_back(out_data);
      tick();
    end
    out_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    #2;
    n_tests++; if (proc_in !== 16'h0) begin n_fail++; $display("FAIL reset_proc_in: got %h want 0000", proc_in); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_tests++; if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    tick();
    Reset = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_write_timing();
    out_ready = 1'b0;
    proc_out  = {1'b1, 16'hA5A5};
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wt_no_bypass: got %b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wt_valid_k1: got %b want 1", out_valid); end
    n_tests++; if (out_data !== 16'hA5A5) begin n_fail++; $display("FAIL wt_data_k1: got %h want a5a5", out_data); end
    tick();
    tick();
    proc_out = {1'b0, 16'h5A5A};
    tick();
    tick();
    drain(10);
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL wt_entries: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_fifo_order();
    exp_q.delete();
    for (int i = 1; i <= 8; i++) begin
      write_word(16'(i));
      exp_q.push_back(16'(i));
    end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL order_no_ovf: got %b want 0", ovf); end
    drain(20);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL order_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_valid_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      write_word(16'h0100 + 16'(i));
      if (i < 8) exp_q.push_back(16'h0100 + 16'(i));
    end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf); end
    n_tests++; if (drop_cnt !== EXP_DROP_TWO) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want %0d", drop_cnt, EXP_DROP_TWO); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr_flag: got %b want 0", ovf); end
    n_tests++; if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL ovf_clr_cnt: got %0d want 0", drop_cnt); end
    drain(20);
    n_tests++; if (got_q.size() != 8) begin n_fail++; $display("FAIL ovf_retained: got %0d want 8", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_push_pop_full();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      write_word(16'h0200 + 16'(i));
      if (i > 0) exp_q.push_back(16'h0200 + 16'(i));
    end
    exp_q.push_back(16'h02FF);
    proc_out  = {1'b1, 16'h02FF};
    out_ready = 1'b1;
    n_tests++; if (out_data !== 16'h0200) begin n_fail++; $display("FAIL ppf_head: got %h want 0200", out_data); end
    tick();
    out_ready = 1'b0;
    proc_out  = {1'b0, 16'h02FF};
    tick();
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ppf_no_ovf: got %b want 0", ovf); end
    n_tests++; if (drop_cnt !== 8'h0) begin n_fail++; $display("FAIL ppf_no_drop: got %0d want 0", drop_cnt); end
    drain(20);
    n_tests++; if (got_q.size() != 8) begin n_fail++; $display("FAIL ppf_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ppf_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_in_path();
    in_data  = 16'h1234;
    in_valid = 1'b1;
    n_tests++; if (proc_in !== 16'h0) begin n_fail++; $display("FAIL in_before: got %h want 0000", proc_in); end
    tick();
    in_valid = 1'b0;
    in_data  = 16'hFFFF;
    n_tests++; if (proc_in !== 16'h1234) begin n_fail++; $display("FAIL in_k1: got %h want 1234", proc_in); end
    tick();
    tick();
    n_tests++; if (proc_in !== 16'h1234) begin n_fail++; $display("FAIL in_hold: got %h want 1234", proc_in); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) write_word(16'h0300 + 16'(i));
    in_data  = 16'hBEEF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_tests++; if (proc_in !== 16'hBEEF) begin n_fail++; $display("FAIL rm_pre_proc_in: got %h want beef", proc_in); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid: got %b want 1", out_valid); end
    #3;
    Reset = 1'b0;
    #1;
    n_tests++; if (proc_in !== 16'h0) begin n_fail++; $display("FAIL rm_proc_in: got %h want 0000", proc_in); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_ready: got %b want 0", in_ready); end
    n_tests++; if (ovf !== 1'b0 || drop_cnt !== 8'h0) begin n_fail++; $display("FAIL rm_ovf: got %b/%0d want 0/0", ovf, drop_cnt); end
    proc_out = {1'b1, 16'h0C0C};
    #2;
    Reset = 1'b1;
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_release_edge: got %b want 1", out_valid); end
    n_tests++; if (out_data !== 16'h0C0C) begin n_fail++; $display("FAIL rm_release_data: got %h want 0c0c", out_data); end
    proc_out = {1'b0, 16'h0C0C};
    tick();
    drain(20);
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rm_flushed: got %0d entries want 1", got_q.size()); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    proc_out  = '0;
    out_ready = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_write_timing();
    test_fifo_order();
    test_overflow();
    test_push_pop_full();
    test_in_path();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
